montinv_corr: RTL

MONTINV_CORR -- requirements
Module: montinv_corr

---
 rtl/montinv_corr_if.sv | 28 ++
 rtl/montinv_corr.sv | 114 +++++++++++
 2 files changed

// File: rtl/montinv_corr_if.sv
// Request/response bundle for the Montgomery almost-inverse correction block.
// The requester drives the operands and controls. The correction block drives
// back the result and the status flags.
interface montinv_corr_if #(
  parameter int WIDTH = 256,
  parameter int CWID  = 10
);
  logic             start;
  logic             clr;
  logic             mode;
  logic [WIDTH-1:0] ainv;
  logic [WIDTH-1:0] mod;
  logic [CWID-1:0]  exp;
  logic [WIDTH-1:0] inv;
  logic             busy;
  logic             vld;
  logic             err;

  modport master (
    output start, clr, mode, ainv, mod, exp,
    input  inv, busy, vld, err
  );

  modport slave (
    input  start, clr, mode, ainv, mod, exp,
    output inv, busy, vld, err
  );
endinterface

// File: rtl/montinv_corr.sv
// Kaliski correction phase. It takes an almost-inverse r = a^-1 * 2^k mod p.
// It then either halves r (exp-WIDTH) times modulo p, or doubles r (2*WIDTH-exp)
// times modulo p. The block performs one step per clock.
module montinv_corr #(
  parameter int WIDTH = 256,
  parameter int CWID  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  montinv_corr_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exponent bounds. The exponent width is chosen so that 2*WIDTH still fits.
  localparam logic [CWID-1:0] EXP_LO = CWID'(WIDTH);
  localparam logic [CWID-1:0] EXP_HI = CWID'(2 * WIDTH);

  state_t           state;
  logic [CWID-1:0]  cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] p;
  logic             md;
  logic             vld;
  logic             err;

  logic             exp_bad;
  logic [CWID-1:0]  cnt_load;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH:0]   dbl;
  logic [WIDTH-1:0] half_odd;

  // Decode the incoming exponent into a range flag and a step count.
  always_comb begin
    exp_bad  = (bus.exp < EXP_LO) || (bus.exp > EXP_HI);
    cnt_load = bus.mode ? (EXP_HI - bus.exp) : (bus.exp - EXP_LO);
  end

  // Compute the next value of r for one halve or double step modulo p.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    r_step   = r;
    dbl      = {r, 1'b0};
    // For odd r, (r+p)>>1 is formed without the WIDTH+1 bit sum.
    // Halving r and p separately gives the same value.
    // The +1 is the carry from the two low ones.
    half_odd = (r >> 1) + (p >> 1) + {{(WIDTH-1){1'b0}}, p[0]};
    if (md) begin
      // When t >= p, t-p < p < 2^WIDTH, so the low WIDTH bits of the difference are exact.
      r_step = (dbl >= {1'b0, p}) ? (dbl[WIDTH-1:0] - p) : dbl[WIDTH-1:0];
    end else begin
      r_step = r[0] ? half_odd : (r >> 1);
    end
  end

  // Control FSM and datapath registers. The registered vld pulse is raised when RUN finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= IDLE;
      cnt   <= '0;
      r     <= '0;
      p     <= '0;
      md    <= 1'b0;
      vld   <= 1'b0;
      err   <= 1'b0;
    end else if (bus.clr) begin
      // Abort: r and err are kept so software can still inspect them.
      state <= IDLE;
      vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld <= 1'b0;
          if (bus.start) begin
            p     <= bus.mod;
            md    <= bus.mode;
            err   <= exp_bad;
            r     <= exp_bad ? '0 : bus.ainv;
            cnt   <= exp_bad ? '0 : cnt_load;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            r   <= r_step;
            cnt <= cnt - 1'b1;
          end else begin
            vld   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          vld   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          vld   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.inv  = r;
  assign bus.busy = (state != IDLE);
  assign bus.vld  = vld;
  assign bus.err  = err;

endmodule
